// File: rtl/dpmemrf_pkg.sv
// Shared definitions for the dpmemrf arbiter: FSM state encodings, the
// requester-id width and the read-tag record carried down the response
// pipeline. Benches import this package to refer to the same encodings.
package dpmemrf_pkg;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam int   ID_W    = 1;

  typedef enum logic {
    S_INIT = ST_INIT,
    S_RUN  = ST_RUN
  } state_e;

  // One entry per accepted access; only entries with is_read set produce
  // a response when they reach the end of the pipeline.
  typedef struct packed {
    logic            is_read;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a 1-bit last-grant pointer.
// Ports:
//   clk, srst    clock, synchronous active-high reset
//   req[1:0]     requests
//   advance      a granted request was accepted; moves the pointer
//   grant[1:0]   one-hot (or zero) grant, combinational from req
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q holds the id of the requester granted last; resetting it to 1
  // hands the first tie to requester 0.
  logic last_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant[1];
    end
  end

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last_q);
    grant[1] = req[1] & (~req[0] | ~last_q);
  end

endmodule

// File: rtl/dpmemrf_arb.sv
// Arbiter placing two requesters onto one port of a dpmemrf memory, with an
// optional clear-after-reset sweep and tagged read-response routing.
// Ports:
//   clk, srst                   clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata    requester N access
//   reqN_ready                  requester N accepted this cycle
//   rspN_valid, rsp_rdata       read data for requester N (shared bus)
//   mem_en/we/addr/di, mem_do   memory port
//   init_done                   clear sweep finished, accepting requests
//
// state  | meaning
// INIT   | sweeping all addresses writing zero, requests held off
// RUN    | round-robin arbitration between the two requesters
module dpmemrf_arb
  import dpmemrf_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int WIDTH   = 32,
  parameter int OUTREG  = 0,
  parameter int INIT_EN = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_we,
  input  logic [DEPTH-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_we,
  input  logic [DEPTH-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_di,
  input  logic [WIDTH-1:0] mem_do,
  output logic             init_done
);

  localparam int LAT = 1 + OUTREG;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] clr_q;
  logic [1:0]       grant;
  logic             run;
  logic             xfer;
  tag_t             tag_d;
  tag_t             tag_q [LAT];

  rr_arb2 u_rr (
    .clk     (clk),
    .srst    (srst),
    .req     ({req1_valid, req0_valid}),
    .advance (xfer),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= (INIT_EN != 0) ? S_INIT : S_RUN;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        clr_q <= clr_q + 1'b1;
      end
    end
  end

  // All outputs are forced to zero while srst is high, not just after the
  // next edge, so the combinational paths are gated by srst as well.
  always_comb begin
    state_d    = state_q;
    run        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_di     = '0;
    init_done  = 1'b0;
    tag_d      = '0;
    case (state_q)
      S_INIT: begin
        if (clr_q == {DEPTH{1'b1}}) begin
          state_d = S_RUN;
        end
        if (!srst) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = clr_q;
        end
      end
      S_RUN: begin
        run        = ~srst;
        init_done  = run;
        req0_ready = run & req0_valid & grant[0];
        req1_ready = run & req1_valid & grant[1];
        xfer       = req0_ready | req1_ready;
        if (xfer) begin
          mem_en   = 1'b1;
          mem_we   = grant[1] ? req1_we    : req0_we;
          mem_addr = grant[1] ? req1_addr  : req0_addr;
          mem_di   = grant[1] ? req1_wdata : req0_wdata;
        end
        tag_d.is_read = xfer & ~mem_we;
        tag_d.id      = grant[1];
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rsp0_valid = ~srst & tag_q[LAT-1].is_read & (tag_q[LAT-1].id == ID_W'(0));
  assign rsp1_valid = ~srst & tag_q[LAT-1].is_read & (tag_q[LAT-1].id == ID_W'(1));
  assign rsp_rdata  = mem_do;

endmodule

// File: doc/dpmemrf_arb.md
DPMEMRF_ARB -- requirements
Module: dpmemrf_arb

Interface
REQ-001 Parameter DEPTH, default 10: address width; the memory holds 2^DEPTH words.
REQ-002 Parameter WIDTH, default 32: data width.
REQ-003 Parameter OUTREG, default 0: matches the attached dpmemrf port's output-register setting; read latency is 1+OUTREG cycles.
REQ-004 Parameter INIT_EN, default 1: 1 enables the clear-after-reset sequence.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 srst  in  1  reset, synchronous and active-high.
REQ-007 req0_valid / req1_valid  in  1  requester n presents an access.
REQ-008 req0_ready / req1_ready  out  1  access of requester n accepted this cycle.
REQ-009 req0_we / req1_we  in  1  1=write, 0=read.
REQ-010 req0_addr / req1_addr  in  DEPTH  access address.
REQ-011 req0_wdata / req1_wdata  in  WIDTH  write data.
REQ-012 rsp0_valid / rsp1_valid  out  1  read data for requester n is valid this cycle.
REQ-013 rsp_rdata  out  WIDTH  read data shared by both requesters, qualified by rspN_valid.
REQ-014 mem_en, mem_we  out  1  to dpmemrf port ena/wea.
REQ-015 mem_addr  out  DEPTH  to dpmemrf port addr.
REQ-016 mem_di  out  WIDTH  to dpmemrf port di.
REQ-017 mem_do  in  WIDTH  from dpmemrf port do.
REQ-018 init_done  out  1  high once the FSM is in RUN.

Function
REQ-019 FSM states: INIT and RUN.
- After reset the FSM enters INIT if INIT_EN=1, otherwise RUN.
REQ-020 INIT behaviour:
- mem_en=1, mem_we=1, mem_di=0, mem_addr=clear counter.
- The counter starts at 0 and increments by 1 per cycle.
- After the cycle that writes address 2^DEPTH-1, the FSM goes to RUN.
- INIT lasts exactly 2^DEPTH cycles.
REQ-021 In INIT, req0_ready=req1_ready=0 and init_done=0; pending requests are held, not dropped.
REQ-022 In RUN, at most one request is granted per cycle.
- readyN = RUN & reqN_valid & grantN, computed combinationally in the same cycle.
- A transfer occurs when reqN_valid & reqN_ready are both high.
REQ-023 Arbitration is round-robin on a 1-bit last-grant pointer.
- Single valid requester: it is granted.
- Both valid: the requester not granted last is granted.
- The pointer updates only on a transfer.
REQ-024 In RUN, mem_en = transfer, and mem_we/mem_addr/mem_di are taken from the granted requester.
- With no transfer, mem_en=0 and mem_we=0.
REQ-025 Read routing:
- Each transfer shifts a {is_read, id} tag into a (1+OUTREG)-deep pipeline.
- rspN_valid=1 exactly 1+OUTREG cycles after a read transfer by requester N, and only then.
- rsp_rdata = mem_do.
REQ-026 Writes produce no response.
- A read and a write on different ports of the same address follow the memory's read-first rule; the arbiter does not modify or check this.
REQ-027 Back-to-back reads from either requester are accepted every cycle.
- Responses return in grant order with no bubbles.
- There is no response backpressure.
REQ-028 A requester whose valid stays high while it loses arbitration shall keep addr/we/wdata stable until its ready is asserted.

Reset
REQ-029 While srst=1, all outputs read zero: mem_en, mem_we, mem_addr, mem_di, readyN, rspN_valid, rsp_rdata-qualifier, init_done.
REQ-030 srst clears the tag pipeline (in-flight reads are discarded and no rspN_valid follows), sets the pointer so requester 0 wins the first tie, zeroes the clear counter, and restarts INIT when INIT_EN=1.
REQ-031 A reset asserted mid-INIT or mid-RUN takes effect on the next rising edge with identical results.

Structure
REQ-032 The state encodings (INIT, RUN) and the requester-id width shall be defined as localparams in a shared dpmemrf_pkg include, so that testbenches can reference them.
REQ-033 A single sub-module, rr_arb2 (2-way round-robin grant with pointer), shall be instantiated once; everything else is flat.

Verification
REQ-034 Test setup: the bench instantiates dpmemrf (DEPTH=4, WIDTH=32) on port A behind dpmemrf_arb, runs each scenario with OUTREG=0 and with OUTREG=1, and flags errors with $display.
REQ-035 Init clear: preload memory with 0xFFFFFFFF, then release srst.
- init_done rises after 16 cycles with no ready asserted before it.
- Reads of addresses 0..15 return 0x00000000.
REQ-036 Contention: both requesters hold valid.
- req0 writes 0x11223344 to address 1; req1 writes 0x55667788 to address 2.
- Grants alternate 0,1,0,1; the first grant after reset goes to requester 0.
REQ-037 Read routing: req0 reads address 1 and req1 reads address 2 in consecutive cycles.
- rsp0_valid with 0x11223344 arrives at T+1+OUTREG.
- rsp1_valid with 0x55667788 arrives one cycle later.
REQ-038 Read-first collision: a port B write of 0xCAFEDECA to address 2 occurs in the same cycle as a req1 read of address 2.
- The req1 response is 0x55667788.
- The next req1 read of address 2 returns 0xCAFEDECA.
REQ-039 Reset mid-read: assert srst in the cycle after a read transfer with OUTREG=1.
- No rspN_valid is produced.
- INIT restarts and init_done drops to 0.
REQ-040 Idle: with no valid inputs for 8 cycles, mem_en stays 0 and the pointer does not change.
